// File: rtl/lcd_spi_stream_ctrl_pkg.sv
// Shared definitions for the ST7735S-class SPI streaming controller:
// panel opcodes, panel geometry, byte timing and the top-level state set.
`timescale 1ns/1ps
package lcd_spi_stream_ctrl_pkg;

    // Panel command opcodes
    localparam logic [7:0] OP_SWRESET = 8'h01;
    localparam logic [7:0] OP_SLPOUT  = 8'h11;
    localparam logic [7:0] OP_INVON   = 8'h21;
    localparam logic [7:0] OP_COLMOD  = 8'h3A;
    localparam logic [7:0] OP_MADCTL  = 8'h36;
    localparam logic [7:0] OP_CASET   = 8'h2A;
    localparam logic [7:0] OP_RASET   = 8'h2B;
    localparam logic [7:0] OP_DISPON  = 8'h29;
    localparam logic [7:0] OP_RAMWR   = 8'h2C;

    // Parameter bytes for the single-parameter init entries
    localparam logic [7:0] COLMOD_RGB565 = 8'h05;
    localparam logic [7:0] MADCTL_LAND   = 8'h68;

    // Visible panel geometry and serial byte length
    localparam int LCD_W       = 160;
    localparam int LCD_H       = 80;
    localparam int BYTE_CYCLES = 18;

    typedef enum logic [2:0] {
        ST_HWRST_LOW,
        ST_HWRST_WAIT,
        ST_INIT,
        ST_CMD_DELAY,
        ST_RAMWR,
        ST_PIXELS
    } state_t;

    // Bytes in an init-table entry: the command plus its parameters
    function automatic logic [2:0] init_len(input logic [3:0] idx);
        case (idx)
            4'd3, 4'd4: return 3'd2;
            4'd5, 4'd6: return 3'd5;
            default:    return 3'd1;
        endcase
    endfunction

    // SWRESET, SLPOUT and DISPON need the panel to settle afterwards
    function automatic logic init_needs_delay(input logic [3:0] idx);
        return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd7);
    endfunction

endpackage

// File: rtl/lcd_spi_stream_ctrl_byte_tx.sv
// 18-cycle write-only SPI byte serializer. A start may be accepted while
// idle or in the final cycle (done), so bytes can run back to back.
`timescale 1ns/1ps
module lcd_spi_byte_tx
    import lcd_spi_stream_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_dc,
    input  logic [7:0] i_byte,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_csx,
    output logic       o_sck,
    output logic       o_sda,
    output logic       o_dc
);

    localparam logic [4:0] LAST_CYCLE = 5'(BYTE_CYCLES - 1);

    logic       r_busy;
    logic [4:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_dc;

    // Cycle counter and shift register; the next bit is presented on the
    // cycle where SCK falls (entering an even cycle c2..c14).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= 5'd0;
            r_shift <= 8'h00;
            r_dc    <= 1'b0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= 5'd0;
            r_shift <= i_byte;
            r_dc    <= i_dc;
        end else if (r_busy) begin
            if (r_cnt == LAST_CYCLE) begin
                r_busy <= 1'b0;
                r_cnt  <= 5'd0;
            end else begin
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt[0] && (r_cnt < 5'd14)) begin
                    r_shift <= {r_shift[6:0], 1'b0};
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == LAST_CYCLE);
    assign o_csx  = ~(r_busy && (r_cnt != LAST_CYCLE));
    assign o_sck  = r_busy && r_cnt[0] && (r_cnt < LAST_CYCLE);
    assign o_sda  = r_shift[7];
    assign o_dc   = r_dc;

endmodule

// File: rtl/lcd_spi_stream_ctrl.sv
// ST7735S-class panel controller: hardware reset pulse, fixed init table,
// then an endless RGB565 test-pattern stream. FRAME_W/FRAME_H default to the
// full panel; smaller values shorten the streamed frame.
// CMD_WAIT_CYCLES must be at least 2.
`timescale 1ns/1ps
module lcd_spi_stream_ctrl
    import lcd_spi_stream_ctrl_pkg::*;
#(
    parameter int RST_LOW_CYCLES  = 100000,
    parameter int RST_WAIT_CYCLES = 1200000,
    parameter int CMD_WAIT_CYCLES = 1200000,
    parameter int COL_OFFSET      = 1,
    parameter int ROW_OFFSET      = 26,
    parameter int FRAME_W         = LCD_W,
    parameter int FRAME_H         = LCD_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_rstn,
    output logic       LCD_CSX,
    output logic       LCD_DC,
    output logic       LCD_SDA,
    output logic       LCD_SCK,
    output logic       SDA_Read,
    output logic       LCD_RSTX,
    output logic [7:0] H_pos,
    output logic [6:0] V_pos,
    output logic [3:0] cmd_num_out,
    output logic [7:0] frame_state_out
);

    localparam logic [20:0] LOW_LAST    = 21'(RST_LOW_CYCLES - 1);
    localparam logic [20:0] WAIT_LAST   = 21'(RST_WAIT_CYCLES - 1);
    localparam logic [20:0] CMD_LAST    = 21'(CMD_WAIT_CYCLES - 1);
    localparam logic [14:0] FRAME_BYTES = 15'(FRAME_W * FRAME_H * 2);
    localparam logic [7:0]  H_LAST      = 8'(FRAME_W - 1);
    localparam logic [6:0]  V_LAST      = 7'(FRAME_H - 1);
    localparam logic [7:0]  COL_FIRST   = 8'(COL_OFFSET);
    localparam logic [7:0]  COL_LAST    = 8'(COL_OFFSET + LCD_W - 1);
    localparam logic [7:0]  ROW_FIRST   = 8'(ROW_OFFSET);
    localparam logic [7:0]  ROW_LAST    = 8'(ROW_OFFSET + LCD_H - 1);
    localparam logic [3:0]  LAST_ENTRY  = 4'd7;
    localparam logic [3:0]  STREAM_IDX  = 4'd8;

    // Byte at position pos of init-table entry idx (pos 0 is the command)
    function automatic logic [7:0] init_byte(input logic [3:0] idx, input logic [2:0] pos);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0: b = OP_SWRESET;
            4'd1: b = OP_SLPOUT;
            4'd2: b = OP_INVON;
            4'd3: b = (pos == 3'd0) ? OP_COLMOD : COLMOD_RGB565;
            4'd4: b = (pos == 3'd0) ? OP_MADCTL : MADCTL_LAND;
            4'd5: begin
                case (pos)
                    3'd0:    b = OP_CASET;
                    3'd2:    b = COL_FIRST;
                    3'd4:    b = COL_LAST;
                    default: b = 8'h00;
                endcase
            end
            4'd6: begin
                case (pos)
                    3'd0:    b = OP_RASET;
                    3'd2:    b = ROW_FIRST;
                    3'd4:    b = ROW_LAST;
                    default: b = 8'h00;
                endcase
            end
            4'd7:    b = OP_DISPON;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Test pattern: red from column, green from row, blue from frame count
    function automatic logic [15:0] pattern(input logic [7:0] h, input logic [6:0] v,
                                            input logic [7:0] f);
        return {h[7:3], v[6:1], f[4:0]};
    endfunction

    state_t      r_state;
    logic [20:0] r_cnt;
    logic [3:0]  r_cmd;
    logic [2:0]  r_pidx;
    logic [14:0] r_bcnt;
    logic [7:0]  r_h;
    logic [6:0]  r_v;
    logic [7:0]  r_frame;
    logic        r_rstx;

    logic        w_rst;
    logic        w_busy;
    logic        w_done;
    logic        w_ready;
    logic        w_start;
    logic        w_tx_dc;
    logic [7:0]  w_tx_byte;
    logic [3:0]  w_cmd_next;
    logic [2:0]  w_len;
    logic [7:0]  w_h_adv;
    logic [6:0]  w_v_adv;
    logic [15:0] w_pix_cur;
    logic [15:0] w_pix_next;

    assign w_rst      = rst | ~sw_rstn;
    assign w_ready    = ~w_busy | w_done;
    assign w_cmd_next = r_cmd + 4'd1;
    assign w_len      = init_len(r_cmd);
    assign w_h_adv    = (r_h == H_LAST) ? 8'd0 : r_h + 8'd1;
    assign w_v_adv    = (r_h != H_LAST) ? r_v : ((r_v == V_LAST) ? 7'd0 : r_v + 7'd1);
    assign w_pix_cur  = pattern(r_h, r_v, r_frame);
    assign w_pix_next = pattern(w_h_adv, w_v_adv, r_frame);

    // Choose the next byte to hand to the serializer; a start issued while
    // done is high makes the following byte begin with no idle cycle.
    always_comb begin
        w_start   = 1'b0;
        w_tx_dc   = 1'b0;
        w_tx_byte = 8'h00;
        case (r_state)
            ST_HWRST_WAIT: begin
                if (r_cnt == WAIT_LAST) begin
                    w_start   = 1'b1;
                    w_tx_byte = OP_SWRESET;
                end
            end
            ST_INIT: begin
                if (w_ready) begin
                    if (r_pidx < w_len) begin
                        w_start   = 1'b1;
                        w_tx_dc   = (r_pidx != 3'd0);
                        w_tx_byte = init_byte(r_cmd, r_pidx);
                    end else if (!init_needs_delay(r_cmd)) begin
                        w_start   = 1'b1;
                        w_tx_byte = init_byte(w_cmd_next, 3'd0);
                    end
                end
            end
            ST_CMD_DELAY: begin
                if (r_cnt == CMD_LAST) begin
                    w_start   = 1'b1;
                    w_tx_byte = (r_cmd == LAST_ENTRY) ? OP_RAMWR : init_byte(w_cmd_next, 3'd0);
                end
            end
            ST_RAMWR: begin
                if (w_done) begin
                    w_start   = 1'b1;
                    w_tx_dc   = 1'b1;
                    w_tx_byte = w_pix_cur[15:8];
                end
            end
            ST_PIXELS: begin
                if (w_done) begin
                    w_start = 1'b1;
                    if (r_bcnt == FRAME_BYTES) begin
                        w_tx_byte = OP_RAMWR;
                    end else begin
                        w_tx_dc   = 1'b1;
                        w_tx_byte = r_bcnt[0] ? w_pix_cur[7:0] : w_pix_next[15:8];
                    end
                end
            end
            default: ;
        endcase
    end

    // Sequencer: reset pulse, init table with settle delays, frame stream
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state <= ST_HWRST_LOW;
            r_cnt   <= 21'd0;
            r_cmd   <= 4'd0;
            r_pidx  <= 3'd0;
            r_bcnt  <= 15'd0;
            r_h     <= 8'd0;
            r_v     <= 7'd0;
            r_frame <= 8'd0;
            r_rstx  <= 1'b0;
        end else begin
            case (r_state)
                ST_HWRST_LOW: begin
                    if (r_cnt == LOW_LAST) begin
                        r_state <= ST_HWRST_WAIT;
                        r_cnt   <= 21'd0;
                        r_rstx  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 21'd1;
                    end
                end
                ST_HWRST_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        r_state <= ST_INIT;
                        r_cnt   <= 21'd0;
                        r_cmd   <= 4'd0;
                        r_pidx  <= 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 21'd1;
                    end
                end
                ST_INIT: begin
                    if (w_ready) begin
                        if (r_pidx < w_len) begin
                            r_pidx <= r_pidx + 3'd1;
                        end else if (init_needs_delay(r_cmd)) begin
                            // The final CSX-high cycle of the byte counts as the first wait cycle
                            r_state <= ST_CMD_DELAY;
                            r_cnt   <= 21'd1;
                        end else begin
                            r_cmd  <= w_cmd_next;
                            r_pidx <= 3'd1;
                        end
                    end
                end
                ST_CMD_DELAY: begin
                    if (r_cnt == CMD_LAST) begin
                        r_cnt <= 21'd0;
                        if (r_cmd == LAST_ENTRY) begin
                            r_state <= ST_RAMWR;
                            r_cmd   <= STREAM_IDX;
                        end else begin
                            r_state <= ST_INIT;
                            r_cmd   <= w_cmd_next;
                            r_pidx  <= 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 21'd1;
                    end
                end
                ST_RAMWR: begin
                    if (w_done) begin
                        r_state <= ST_PIXELS;
                        r_bcnt  <= 15'd1;
                    end
                end
                ST_PIXELS: begin
                    if (w_done) begin
                        if (r_bcnt == FRAME_BYTES) begin
                            r_state <= ST_RAMWR;
                            r_bcnt  <= 15'd0;
                            r_h     <= 8'd0;
                            r_v     <= 7'd0;
                            r_frame <= r_frame + 8'd1;
                        end else begin
                            r_bcnt <= r_bcnt + 15'd1;
                            // An even count means the low byte just finished
                            if (!r_bcnt[0]) begin
                                r_h <= w_h_adv;
                                r_v <= w_v_adv;
                            end
                        end
                    end
                end
                default: r_state <= ST_HWRST_LOW;
            endcase
        end
    end

    lcd_spi_byte_tx u_tx (
        .clk     (clk),
        .rst     (w_rst),
        .i_start (w_start),
        .i_dc    (w_tx_dc),
        .i_byte  (w_tx_byte),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_csx   (LCD_CSX),
        .o_sck   (LCD_SCK),
        .o_sda   (LCD_SDA),
        .o_dc    (LCD_DC)
    );

    assign SDA_Read        = 1'b0;
    assign LCD_RSTX        = r_rstx;
    assign H_pos           = r_h;
    assign V_pos           = r_v;
    assign cmd_num_out     = r_cmd;
    assign frame_state_out = r_frame;

endmodule

// File: tb/tb_lcd_spi_stream_ctrl.sv
// Bench for lcd_spi_stream_ctrl: decodes the SPI stream and compares every
// byte, its timing and the position/status outputs with a byte-list model.
`timescale 1ns/1ps
module tb_lcd_spi_stream_ctrl;

    localparam int RST_LOW  = 10;
    localparam int RST_WAIT = 20;
    localparam int CMD_WAIT = 30;
    localparam int COL_OFF  = 1;
    localparam int ROW_OFF  = 26;
    localparam int FW       = 16;
    localparam int FH       = 4;
    localparam int FRAME_PERIOD = 18 + FW * FH * 2 * 18;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_rstn;
    logic       LCD_CSX, LCD_DC, LCD_SDA, LCD_SCK, SDA_Read, LCD_RSTX;
    logic [7:0] H_pos;
    logic [6:0] V_pos;
    logic [3:0] cmd_num_out;
    logic [7:0] frame_state_out;

    lcd_spi_stream_ctrl #(
        .RST_LOW_CYCLES  (RST_LOW),
        .RST_WAIT_CYCLES (RST_WAIT),
        .CMD_WAIT_CYCLES (CMD_WAIT),
        .COL_OFFSET      (COL_OFF),
        .ROW_OFFSET      (ROW_OFF),
        .FRAME_W         (FW),
        .FRAME_H         (FH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sw_rstn         (sw_rstn),
        .LCD_CSX         (LCD_CSX),
        .LCD_DC          (LCD_DC),
        .LCD_SDA         (LCD_SDA),
        .LCD_SCK         (LCD_SCK),
        .SDA_Read        (SDA_Read),
        .LCD_RSTX        (LCD_RSTX),
        .H_pos           (H_pos),
        .V_pos           (V_pos),
        .cmd_num_out     (cmd_num_out),
        .frame_state_out (frame_state_out)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Expected byte list: dcb = dc*256 + byte; gap = cycles since the previous
    // byte started (-1: first byte, timed from LCD_RSTX rising); h = -1 when
    // the position is not checked.
    typedef struct {
        int dcb;
        int gap;
        int cmd;
        int frame;
        int h;
        int v;
    } exp_t;
    exp_t expq[$];

    task automatic add_exp(input int dc, input int b, input int gap, input int cmd,
                           input int fr, input int h, input int v);
        exp_t e;
        e.dcb = dc * 256 + b; e.gap = gap; e.cmd = cmd; e.frame = fr; e.h = h; e.v = v;
        expq.push_back(e);
    endtask

    task automatic build_expected(input int frames);
        int tbl [8][5];
        int len [8];
        int gap;
        int pix;
        bit delay_pending;
        tbl[0] = '{8'h01, 0, 0, 0, 0};
        tbl[1] = '{8'h11, 0, 0, 0, 0};
        tbl[2] = '{8'h21, 0, 0, 0, 0};
        tbl[3] = '{8'h3A, 8'h05, 0, 0, 0};
        tbl[4] = '{8'h36, 8'h68, 0, 0, 0};
        tbl[5] = '{8'h2A, 0, COL_OFF, 0, COL_OFF + 159};
        tbl[6] = '{8'h2B, 0, ROW_OFF, 0, ROW_OFF + 79};
        tbl[7] = '{8'h29, 0, 0, 0, 0};
        len    = '{1, 1, 1, 2, 2, 5, 5, 1};
        delay_pending = 1'b0;
        gap = -1;
        for (int e = 0; e < 8; e++) begin
            for (int p = 0; p < len[e]; p++) begin
                add_exp((p == 0) ? 0 : 1, tbl[e][p], gap, e, 0, -1, -1);
                gap = 18;
            end
            if (e == 0 || e == 1 || e == 7) gap = 17 + CMD_WAIT;
        end
        for (int f = 0; f < frames; f++) begin
            add_exp(0, 8'h2C, gap, 8, f, -1, -1);
            gap = 18;
            for (int v = 0; v < FH; v++) begin
                for (int h = 0; h < FW; h++) begin
                    pix = (h / 8) * 2048 + (v / 2) * 32 + (f % 32);
                    add_exp(1, pix / 256, 18, 8, f, h, v);
                    add_exp(1, pix % 256, 18, 8, f, h, v);
                end
            end
        end
    endtask

    // Stream decoder, sampled on the falling clock edge
    initial begin
        int ncyc, idx, lowrun, rise_cyc, prev_start, start_cyc, lowcnt, bits;
        int h0, v0, cmd0, fr0, obs;
        bit in_byte, prev_csx, prev_sck, prev_rstx, dc0, dc_bad;
        logic [7:0] shreg;
        ncyc = 0; idx = 0; lowrun = 0; rise_cyc = 0; prev_start = 0; start_cyc = 0;
        lowcnt = 0; bits = 0; h0 = 0; v0 = 0; cmd0 = 0; fr0 = 0; obs = 0;
        in_byte = 0; prev_csx = 1; prev_sck = 0; prev_rstx = 0; dc0 = 0; dc_bad = 0;
        shreg = 8'h00;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst || !sw_rstn) begin
                in_byte = 0; idx = 0; lowrun = 0;
                prev_csx = 1; prev_sck = 0; prev_rstx = 0;
            end else begin
                if (!LCD_RSTX) lowrun++;
                if (LCD_RSTX && !prev_rstx) begin
                    check("rstx_low_cycles", lowrun, RST_LOW);
                    rise_cyc = ncyc;
                end
                if (prev_csx && !LCD_CSX) begin
                    in_byte = 1; start_cyc = ncyc; lowcnt = 0; bits = 0; shreg = 8'h00;
                    dc0 = LCD_DC; dc_bad = 0;
                    h0 = int'(H_pos); v0 = int'(V_pos); cmd0 = int'(cmd_num_out);
                    fr0 = int'(frame_state_out);
                end
                if (in_byte && !LCD_CSX) begin
                    lowcnt++;
                    if (LCD_DC != dc0) dc_bad = 1;
                    if (LCD_SCK && !prev_sck) begin
                        shreg = {shreg[6:0], LCD_SDA};
                        bits++;
                    end
                end
                if (in_byte && !prev_csx && LCD_CSX) begin
                    in_byte = 0;
                    if (idx < expq.size()) begin
                        obs = (dc0 ? 256 : 0) + int'(shreg);
                        check($sformatf("byte[%0d]", idx), obs, expq[idx].dcb);
                        check($sformatf("sck_edges[%0d]", idx), bits, 8);
                        check($sformatf("csx_low[%0d]", idx), lowcnt, 17);
                        check($sformatf("dc_stable[%0d]", idx), int'(dc_bad), 0);
                        if (expq[idx].gap < 0)
                            check("first_cmd_after_rstx", start_cyc - rise_cyc, RST_WAIT);
                        else
                            check($sformatf("byte_spacing[%0d]", idx), start_cyc - prev_start,
                                  expq[idx].gap);
                        check($sformatf("cmd_num[%0d]", idx), cmd0, expq[idx].cmd);
                        check($sformatf("frame[%0d]", idx), fr0, expq[idx].frame);
                        if (expq[idx].h >= 0) begin
                            check($sformatf("h_pos[%0d]", idx), h0, expq[idx].h);
                            check($sformatf("v_pos[%0d]", idx), v0, expq[idx].v);
                        end
                    end
                    prev_start = start_cyc;
                    idx++;
                end
                prev_csx  = LCD_CSX;
                prev_sck  = LCD_SCK;
                prev_rstx = LCD_RSTX;
            end
        end
    end

    task automatic wait_frame(input int tgt, input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (int'(frame_state_out) == tgt) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check($sformatf("wait_frame_%0d_timeout", tgt), int'(frame_state_out), tgt);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_csx"},   int'(LCD_CSX), 1);
        check({pfx, "_sck"},   int'(LCD_SCK), 0);
        check({pfx, "_rstx"},  int'(LCD_RSTX), 0);
        check({pfx, "_h"},     int'(H_pos), 0);
        check({pfx, "_v"},     int'(V_pos), 0);
        check({pfx, "_cmd"},   int'(cmd_num_out), 0);
        check({pfx, "_frame"}, int'(frame_state_out), 0);
        check({pfx, "_sdard"}, int'(SDA_Read), 0);
    endtask

    initial begin
        int  cyc;
        int  d;
        bit  ok;
        rst = 1'b1;
        sw_rstn = 1'b1;
        build_expected(3);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        check("reset_sda", int'(LCD_SDA), 0);
        check("reset_dc",  int'(LCD_DC), 0);

        @(posedge clk);
        #1 rst = 1'b0;

        wait_frame(1, 20000, cyc, ok);
        if (ok) begin
            check("wrap1_h",   int'(H_pos), 0);
            check("wrap1_v",   int'(V_pos), 0);
            check("wrap1_cmd", int'(cmd_num_out), 8);
            wait_frame(2, 3 * FRAME_PERIOD, cyc, ok);
            if (ok) check("frame_period", cyc, FRAME_PERIOD);
        end

        // Soft reset at a random point inside the third frame
        d = int'($urandom_range(40, FRAME_PERIOD - 100));
        repeat (d) @(posedge clk);
        #1 sw_rstn = 1'b0;
        @(posedge clk);
        #1 sw_rstn = 1'b1;
        @(negedge clk);
        check_reset_state("swrst");

        wait_frame(1, 20000, cyc, ok);
        if (ok) begin
            check("rewrap_h",   int'(H_pos), 0);
            check("rewrap_v",   int'(V_pos), 0);
            check("rewrap_cmd", int'(cmd_num_out), 8);
        end
        repeat (300) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
